// File: rtl/alct_prbs_gen_chk_if.sv
// Bus bundle for the ALCT PRBS generator/checker: generator controls and
// word, received-word input and checker status.
interface alct_prbs_gen_chk_if #(
  parameter int WIDTH        = 49,
  parameter int ERR_CNT_BITS = 16
);
  logic                    ce;
  logic                    seed_load;
  logic [WIDTH-1:0]        seed_in;
  logic [WIDTH-1:0]        lfsr;
  logic [WIDTH-1:0]        rx_data;
  logic                    rx_valid;
  logic                    err_clear;
  logic                    locked;
  logic                    err_flag;
  logic [ERR_CNT_BITS-1:0] err_cnt;
  logic [1:0]              chk_state;

  // Handshake: rx_valid qualifies rx_data for exactly one sample per clock.
  // There is no backpressure, so every valid word is consumed on the edge
  // where it is presented.
  modport master (
    output ce, seed_load, seed_in, rx_data, rx_valid, err_clear,
    input  lfsr, locked, err_flag, err_cnt, chk_state
  );

  modport slave (
    input  ce, seed_load, seed_in, rx_data, rx_valid, err_clear,
    output lfsr, locked, err_flag, err_cnt, chk_state
  );
endinterface

// File: rtl/alct_prbs_gen_chk.sv
// PRBS generator (Fibonacci LFSR, XNOR feedback) and self-synchronising
// checker used for ALCT loopback and cable qualification.
module alct_prbs_gen_chk #(
  parameter int               WIDTH        = 49,
  parameter int               TAP_A        = 48,
  parameter int               TAP_B        = 39,
  parameter logic [WIDTH-1:0] SEED         = 49'h123456789ABCD,
  parameter int               LOCK_CNT     = 8,
  parameter int               UNLOCK_ERRS  = 4,
  parameter int               ERR_CNT_BITS = 16
) (
  input logic                clock,
  input logic                reset,
  alct_prbs_gen_chk_if.slave bus
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int BR_W = $clog2(UNLOCK_ERRS + 1);

  // Counter value just before the event that crosses the threshold.
  localparam logic [MC_W-1:0] LOCK_LAST   = MC_W'(LOCK_CNT - 1);
  localparam logic [BR_W-1:0] UNLOCK_LAST = BR_W'(UNLOCK_ERRS - 1);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], ~(x[TAP_A] ^ x[TAP_B])};
  endfunction

  logic [WIDTH-1:0]        lfsr_q;
  logic [WIDTH-1:0]        exp_q;
  logic [MC_W-1:0]         match_cnt;
  logic [BR_W-1:0]         bad_run;
  chk_state_t              state;
  logic                    locked_q;
  logic                    err_flag_q;
  logic [ERR_CNT_BITS-1:0] err_cnt_q;

  logic seek_match;
  logic lock_miss;

  // The all-ones word is the LFSR lock-up state, so it never counts as a
  // match while searching; otherwise a stuck-high line would lock.
  assign seek_match = (bus.rx_data == exp_q) && (bus.rx_data != ALL_ONES);
  assign lock_miss  = bus.rx_valid && (state == ST_LOCKED) && (bus.rx_data != exp_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (bus.seed_load) begin
      lfsr_q <= bus.seed_in;
    end else if (bus.ce) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_q      <= '0;
      match_cnt  <= '0;
      bad_run    <= '0;
      state      <= ST_IDLE;
      locked_q   <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_flag_q <= lock_miss;

      // A clear coinciding with a counted error leaves that error in the count.
      if (bus.err_clear) begin
        err_cnt_q <= lock_miss ? ERR_CNT_BITS'(1) : '0;
      end else if (lock_miss && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_BITS'(1);
      end

      if (bus.rx_valid) begin
        case (state)
          ST_IDLE: begin
            exp_q     <= lfsr_next(bus.rx_data);
            match_cnt <= '0;
            state     <= ST_SEEK;
          end
          ST_SEEK: begin
            exp_q <= lfsr_next(bus.rx_data);
            if (seek_match) begin
              match_cnt <= match_cnt + MC_W'(1);
              if (match_cnt == LOCK_LAST) begin
                state    <= ST_LOCKED;
                locked_q <= 1'b1;
                bad_run  <= '0;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-running expectation: a corrupted word must not reseed it.
            exp_q <= lfsr_next(exp_q);
            if (lock_miss) begin
              bad_run <= bad_run + BR_W'(1);
              if (bad_run == UNLOCK_LAST) begin
                state     <= ST_IDLE;
                locked_q  <= 1'b0;
                match_cnt <= '0;
              end
            end else begin
              bad_run <= '0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.lfsr      = lfsr_q;
  assign bus.locked    = locked_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.chk_state = state;

endmodule

// File: tb/tb_alct_prbs_gen_chk.sv
// Bench for alct_prbs_gen_chk: two instances (16-bit and 2-bit error counter)
// share one stimulus stream; outputs are checked against a reference model.
module tb_alct_prbs_gen_chk;

  localparam int          W         = 49;
  localparam int          TA        = 48;
  localparam int          TB        = 39;
  localparam int          LOCK_N    = 8;
  localparam int          UNLOCK_N  = 4;
  localparam logic [W-1:0] SEED_V   = 49'h123456789ABCD;
  localparam logic [W-1:0] ONES     = '1;

  logic clock;
  logic reset;
  logic ce, seed_load, rx_valid, err_clear;
  logic [W-1:0] seed_in, rx_data;

  alct_prbs_gen_chk_if #(.WIDTH(W), .ERR_CNT_BITS(16)) bus ();
  alct_prbs_gen_chk_if #(.WIDTH(W), .ERR_CNT_BITS(2))  bus2 ();

  assign bus.ce         = ce;
  assign bus.seed_load  = seed_load;
  assign bus.seed_in    = seed_in;
  assign bus.rx_data    = rx_data;
  assign bus.rx_valid   = rx_valid;
  assign bus.err_clear  = err_clear;
  assign bus2.ce        = ce;
  assign bus2.seed_load = seed_load;
  assign bus2.seed_in   = seed_in;
  assign bus2.rx_data   = rx_data;
  assign bus2.rx_valid  = rx_valid;
  assign bus2.err_clear = err_clear;

  alct_prbs_gen_chk #(.ERR_CNT_BITS(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  alct_prbs_gen_chk #(.ERR_CNT_BITS(2))  dut2 (.clock(clock), .reset(reset), .bus(bus2));

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [21:0]   chk_q[$];

  // Reference model state
  logic [W-1:0] m_gen, m_exp;
  int m_mc, m_br, m_st, m_cnt, m_cnt2;
  logic m_flag;

  function automatic logic [W-1:0] nxt(input logic [W-1:0] x);
    return {x[W-2:0], ~(x[TA] ^ x[TB])};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input logic i_ce, input logic i_sl, input logic [W-1:0] i_seed,
                            input logic i_rv, input logic [W-1:0] i_rd, input logic i_clr,
                            input logic i_rst);
    logic counted;
    counted = 1'b0;
    if (i_rst) begin
      m_gen = SEED_V; m_exp = '0; m_mc = 0; m_br = 0; m_st = 0;
      m_flag = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (i_sl) m_gen = i_seed;
      else if (i_ce) m_gen = nxt(m_gen);
      m_flag = 1'b0;
      if (i_rv) begin
        case (m_st)
          0: begin
            m_exp = nxt(i_rd); m_mc = 0; m_st = 1;
          end
          1: begin
            if (i_rd == m_exp && i_rd != ONES) begin
              m_mc++;
              if (m_mc == LOCK_N) begin m_st = 2; m_br = 0; end
            end else begin
              m_mc = 0;
            end
            m_exp = nxt(i_rd);
          end
          default: begin
            if (i_rd != m_exp) begin
              m_flag = 1'b1; counted = 1'b1; m_br++;
              if (m_br == UNLOCK_N) begin m_st = 0; m_mc = 0; end
            end else begin
              m_br = 0;
            end
            m_exp = nxt(m_exp);
          end
        endcase
      end
      if (i_clr) begin
        m_cnt = counted ? 1 : 0;
        m_cnt2 = counted ? 1 : 0;
      end else if (counted) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  // Driver: apply one cycle, predict, then compare after the edge.
  task automatic drive(input logic i_ce, input logic i_sl, input logic [W-1:0] i_seed,
                       input logic i_rv, input logic [W-1:0] i_rd, input logic i_clr,
                       input logic i_rst);
    logic [W-1:0] e;
    logic [21:0]  c;
    ce = i_ce; seed_load = i_sl; seed_in = i_seed;
    rx_valid = i_rv; rx_data = i_rd; err_clear = i_clr; reset = i_rst;
    model_step(i_ce, i_sl, i_seed, i_rv, i_rd, i_clr, i_rst);
    exp_q.push_back(m_gen);
    chk_q.push_back({2'(m_st), (m_st == 2), m_flag, 16'(m_cnt), 2'(m_cnt2)});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    c = chk_q.pop_front();
    check("lfsr",      64'(bus.lfsr),      64'(e));
    check("chk_state", 64'(bus.chk_state), 64'(c[21:20]));
    check("locked",    64'(bus.locked),    64'(c[19]));
    check("err_flag",  64'(bus.err_flag),  64'(c[18]));
    check("err_cnt",   64'(bus.err_cnt),   64'(c[17:2]));
    check("err_cnt2",  64'(bus2.err_cnt),  64'(c[1:0]));
  endtask

  // Loopback: rx_data is the generator word, optionally corrupted by mask.
  task automatic loop(input int n, input logic gaps, input logic [W-1:0] mask, input logic clr);
    logic v;
    for (int i = 0; i < n; i++) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(v, 1'b0, '0, v, m_gen ^ mask, clr, 1'b0);
    end
  endtask

  function automatic logic [W-1:0] rand_bit();
    logic [W-1:0] one;
    one = 1;
    return one << $urandom_range(0, W - 1);
  endfunction

  typedef struct {
    logic         sl;
    logic [W-1:0] seed;
    logic         ce;
    logic [W-1:0] exp_lfsr;
  } gen_vec_t;

  gen_vec_t gv[8];

  initial begin
    ce = 0; seed_load = 0; seed_in = '0; rx_valid = 0; rx_data = '0; err_clear = 0; reset = 1;
    m_gen = '0; m_exp = '0; m_mc = 0; m_br = 0; m_st = 0; m_cnt = 0; m_cnt2 = 0; m_flag = 0;

    gv[0] = '{1'b0, '0,          1'b1, 49'h0468ACF13579A};
    gv[1] = '{1'b0, '0,          1'b0, 49'h0468ACF13579A};
    gv[2] = '{1'b1, 49'h1,       1'b1, 49'h1};
    gv[3] = '{1'b0, '0,          1'b1, 49'h3};
    gv[4] = '{1'b0, '0,          1'b1, 49'h7};
    gv[5] = '{1'b1, ONES,        1'b0, ONES};
    gv[6] = '{1'b0, '0,          1'b1, ONES};
    gv[7] = '{1'b1, SEED_V,      1'b0, SEED_V};

    // Reset state
    drive(0, 0, '0, 0, '0, 0, 1);
    drive(0, 0, '0, 0, '0, 0, 1);
    check("rst_lfsr",    64'(bus.lfsr),      64'(SEED_V));
    check("rst_locked",  64'(bus.locked),    64'd0);
    check("rst_err_cnt", 64'(bus.err_cnt),   64'd0);
    check("rst_state",   64'(bus.chk_state), 64'd0);

    // Generator vectors
    for (int i = 0; i < 8; i++) begin
      drive(gv[i].ce, gv[i].sl, gv[i].seed, 1'b0, '0, 1'b0, 1'b0);
      check($sformatf("gen_vec%0d", i), 64'(bus.lfsr), 64'(gv[i].exp_lfsr));
    end

    // Loopback lock-in from reset
    drive(0, 0, '0, 0, '0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      loop(1, 1'b0, '0, 1'b0);
      if (k == 1) check("seek_after_1", 64'(bus.chk_state), 64'd1);
      if (k == 8) check("unlocked_at_8", 64'(bus.locked), 64'd0);
      if (k == 9) check("locked_at_9", 64'(bus.locked), 64'd1);
    end
    check("state_locked", 64'(bus.chk_state), 64'd2);

    loop(1000, 1'b1, '0, 1'b0);
    check("clean_err_cnt", 64'(bus.err_cnt), 64'd0);
    check("clean_locked",  64'(bus.locked),  64'd1);

    // Single bit-17 flip while locked
    loop(1, 1'b0, 49'h1 << 17, 1'b0);
    check("flip_flag",   64'(bus.err_flag), 64'd1);
    check("flip_cnt",    64'(bus.err_cnt),  64'd1);
    check("flip_locked", 64'(bus.locked),   64'd1);
    loop(20, 1'b0, '0, 1'b0);
    check("after_flip_cnt",  64'(bus.err_cnt),  64'd1);
    check("after_flip_flag", 64'(bus.err_flag), 64'd0);

    // Clear, then four consecutive bad words drop lock
    drive(0, 0, '0, 0, '0, 1, 0);
    check("clear_cnt", 64'(bus.err_cnt), 64'd0);
    for (int k = 0; k < 4; k++) loop(1, 1'b0, rand_bit(), 1'b0);
    check("burst_cnt",   64'(bus.err_cnt),   64'd4);
    check("burst_state", 64'(bus.chk_state), 64'd0);
    check("burst_cnt2",  64'(bus2.err_cnt),  64'd3);
    for (int k = 1; k <= 9; k++) begin
      loop(1, 1'b0, '0, 1'b0);
      if (k == 8) check("relock_not_8", 64'(bus.locked), 64'd0);
      if (k == 9) check("relock_at_9",  64'(bus.locked), 64'd1);
    end

    // Fifth error: small counter stays saturated
    loop(1, 1'b0, rand_bit(), 1'b0);
    check("fifth_cnt",  64'(bus.err_cnt),  64'd5);
    check("sat_cnt2",   64'(bus2.err_cnt), 64'd3);
    check("sat_flag2",  64'(bus2.err_flag), 64'd1);
    loop(1, 1'b0, '0, 1'b0);
    loop(1, 1'b0, rand_bit(), 1'b1);
    check("clr_err_cnt",  64'(bus.err_cnt),  64'd1);
    check("clr_err_cnt2", 64'(bus2.err_cnt), 64'd1);
    check("clr_locked",   64'(bus.locked),   64'd1);
    loop(5, 1'b0, '0, 1'b0);

    // Reset mid-operation overrides every other input
    drive(1, 1, ONES, 1, ONES, 1, 1);
    check("midrst_lfsr",  64'(bus.lfsr),      64'(SEED_V));
    check("midrst_state", 64'(bus.chk_state), 64'd0);
    check("midrst_cnt",   64'(bus.err_cnt),   64'd0);

    // Stuck-high line never locks
    for (int k = 0; k < 100; k++) drive(0, 0, '0, 1, ONES, 0, 0);
    check("ones_locked", 64'(bus.locked),    64'd0);
    check("ones_cnt",    64'(bus.err_cnt),   64'd0);
    check("ones_state",  64'(bus.chk_state), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
